// File: rtl/matmul_seq.sv
// Sequential signed fixed-point matrix multiplier: C = A x B (or A x B^T), one MAC per cycle,
// with round-half-up, saturation to DATA_WIDTH and a sticky saturation flag.
module matmul_seq #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned BIN_POS    = 16,
   parameter int unsigned ROWS_A     = 3,
   parameter int unsigned INNER      = 3,
   parameter int unsigned COLS_B     = 3
) (
   input  logic                                   clk,
   input  logic                                   rst,
   output logic                                   ready,
   output logic                                   complete,
   input  logic [ROWS_A*INNER*DATA_WIDTH-1:0]     a,
   input  logic [INNER*COLS_B*DATA_WIDTH-1:0]     b,
   input  logic                                   transpose_b,
   output logic [ROWS_A*COLS_B*DATA_WIDTH-1:0]    c,
   output logic                                   overflow
);

   localparam int unsigned IW   = (ROWS_A > 1) ? $clog2(ROWS_A) : 1;
   localparam int unsigned JW   = (COLS_B > 1) ? $clog2(COLS_B) : 1;
   localparam int unsigned KW   = (INNER > 1) ? $clog2(INNER) : 1;
   localparam int unsigned AccW = 2 * DATA_WIDTH + $clog2(INNER) + 1;
   localparam int unsigned ExtW = AccW - 2 * DATA_WIDTH;

   localparam logic [IW-1:0] ILast = IW'(ROWS_A - 1);
   localparam logic [JW-1:0] JLast = JW'(COLS_B - 1);
   localparam logic [KW-1:0] KLast = KW'(INNER - 1);

   localparam logic [AccW:0] One  = {{AccW{1'b0}}, 1'b1};
   localparam logic [AccW:0] Half = (BIN_POS > 0) ? (One << ((BIN_POS > 0) ? BIN_POS - 1 : 0))
                                                  : '0;
   localparam logic signed [AccW:0] SatMax = {{(AccW + 2 - DATA_WIDTH){1'b0}},
                                              {(DATA_WIDTH - 1){1'b1}}};
   localparam logic signed [AccW:0] SatMin = {{(AccW + 2 - DATA_WIDTH){1'b1}},
                                              {(DATA_WIDTH - 1){1'b0}}};

   typedef enum logic [1:0] {StIdle, StMac, StStore, StDone} state_e;

   state_e                                 state_q, state_d;
   logic [ROWS_A*INNER*DATA_WIDTH-1:0]     a_q, a_d;
   logic [INNER*COLS_B*DATA_WIDTH-1:0]     b_q, b_d;
   logic                                   tb_q, tb_d;
   logic [ROWS_A*COLS_B*DATA_WIDTH-1:0]    c_q, c_d;
   logic                                   ovf_q, ovf_d;
   logic [IW-1:0]                          i_q, i_d;
   logic [JW-1:0]                          j_q, j_d;
   logic [KW-1:0]                          k_q, k_d;
   logic signed [AccW-1:0]                 acc_q, acc_d;

   int                                     a_idx, b_idx, c_idx;
   logic signed [DATA_WIDTH-1:0]           a_el, b_el;
   logic signed [2*DATA_WIDTH-1:0]         prod;
   logic signed [AccW:0]                   rnd_sum, shifted;
   logic [DATA_WIDTH-1:0]                  res;
   logic                                   sat;

   // Operand fetch: B^T mode reads the b vector as an N x K row-major matrix.
   always_comb begin
      a_idx = int'(i_q) * INNER + int'(k_q);
      b_idx = tb_q ? (int'(j_q) * INNER + int'(k_q)) : (int'(k_q) * COLS_B + int'(j_q));
      c_idx = int'(i_q) * COLS_B + int'(j_q);
      a_el  = a_q[a_idx*DATA_WIDTH +: DATA_WIDTH];
      b_el  = b_q[b_idx*DATA_WIDTH +: DATA_WIDTH];
      prod  = a_el * b_el;
   end

   always_comb begin
      rnd_sum = {acc_q[AccW-1], acc_q} + Half;
      shifted = rnd_sum >>> BIN_POS;
      sat     = 1'b0;
      res     = shifted[DATA_WIDTH-1:0];
      if (shifted > SatMax) begin
         res = SatMax[DATA_WIDTH-1:0];
         sat = 1'b1;
      end else if (shifted < SatMin) begin
         res = SatMin[DATA_WIDTH-1:0];
         sat = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      tb_d    = tb_q;
      c_d     = c_q;
      ovf_d   = ovf_q;
      i_d     = i_q;
      j_d     = j_q;
      k_d     = k_q;
      acc_d   = acc_q;
      unique case (state_q)
         StIdle: begin
            a_d     = a;
            b_d     = b;
            tb_d    = transpose_b;
            ovf_d   = 1'b0;
            i_d     = '0;
            j_d     = '0;
            k_d     = '0;
            acc_d   = '0;
            state_d = StMac;
         end
         StMac: begin
            acc_d = acc_q + {{ExtW{prod[2*DATA_WIDTH-1]}}, prod};
            if (k_q == KLast) begin
               state_d = StStore;
            end else begin
               k_d = k_q + KW'(1);
            end
         end
         StStore: begin
            c_d[c_idx*DATA_WIDTH +: DATA_WIDTH] = res;
            ovf_d   = ovf_q | sat;
            acc_d   = '0;
            k_d     = '0;
            state_d = StMac;
            if (j_q == JLast) begin
               j_d = '0;
               if (i_q == ILast) begin
                  state_d = StDone;
               end else begin
                  i_d = i_q + IW'(1);
               end
            end else begin
               j_d = j_q + JW'(1);
            end
         end
         StDone: begin
            state_d = StDone;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         tb_q    <= 1'b0;
         c_q     <= '0;
         ovf_q   <= 1'b0;
         i_q     <= '0;
         j_q     <= '0;
         k_q     <= '0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         tb_q    <= tb_d;
         c_q     <= c_d;
         ovf_q   <= ovf_d;
         i_q     <= i_d;
         j_q     <= j_d;
         k_q     <= k_d;
         acc_q   <= acc_d;
      end
   end

   assign ready    = (state_q == StIdle);
   assign complete = (state_q == StDone);
   assign c        = c_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_matmul_seq.sv
// Directed bench for matmul_seq: 3x3x3, 2x3x4 (transpose) and 1x1x1 instances.
module tb_matmul_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // 3x3x3 instance
   logic          rst3, ready3, complete3, tb3, ovf3;
   logic [287:0]  a3, b3, c3;
   // 2x3x4 instance
   logic          rst2, ready2, complete2, tb2, ovf2;
   logic [191:0]  a2;
   logic [383:0]  b2;
   logic [255:0]  c2;
   // 1x1x1 instance
   logic          rst1, ready1, complete1, tb1, ovf1;
   logic [31:0]   a1, b1, c1;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] snap [9];

   matmul_seq #(.DATA_WIDTH(32), .BIN_POS(16), .ROWS_A(3), .INNER(3), .COLS_B(3)) u3 (
      .clk(clk), .rst(rst3), .ready(ready3), .complete(complete3), .a(a3), .b(b3),
      .transpose_b(tb3), .c(c3), .overflow(ovf3));

   matmul_seq #(.DATA_WIDTH(32), .BIN_POS(16), .ROWS_A(2), .INNER(3), .COLS_B(4)) u2 (
      .clk(clk), .rst(rst2), .ready(ready2), .complete(complete2), .a(a2), .b(b2),
      .transpose_b(tb2), .c(c2), .overflow(ovf2));

   matmul_seq #(.DATA_WIDTH(32), .BIN_POS(16), .ROWS_A(1), .INNER(1), .COLS_B(1)) u1 (
      .clk(clk), .rst(rst1), .ready(ready1), .complete(complete1), .a(a1), .b(b1),
      .transpose_b(tb1), .c(c1), .overflow(ovf1));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic load_identity3();
      for (int e = 0; e < 9; e++) begin
         a3[e*32 +: 32] = (e % 4 == 0) ? 32'h0001_0000 : 32'h0;
         b3[e*32 +: 32] = 32'h0001_0000 * (e + 1);
      end
      tb3 = 1'b0;
   endtask

   task automatic run1(input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] cexp, input logic oexp, input string tag);
      rst1 = 1'b1;
      tick();
      check({tag, "_rst_ovf"}, {31'b0, ovf1}, 32'd0);
      check({tag, "_rst_c"}, c1, 32'd0);
      a1   = av;
      b1   = bv;
      rst1 = 1'b0;
      repeat (2) tick();
      check({tag, "_pre"}, {31'b0, complete1}, 32'd0);
      tick();
      check({tag, "_done"}, {31'b0, complete1}, 32'd1);
      check({tag, "_c"}, c1, cexp);
      check({tag, "_ovf"}, {31'b0, ovf1}, {31'b0, oexp});
   endtask

   initial begin
      rst3 = 1'b1; rst2 = 1'b1; rst1 = 1'b1;
      a3 = '0; b3 = '0; tb3 = 1'b0;
      a2 = '0; b2 = '0; tb2 = 1'b0;
      a1 = '0; b1 = '0; tb1 = 1'b0;
      repeat (2) tick();

      // Reset state
      check("rst_ready", {31'b0, ready3}, 32'd1);
      check("rst_complete", {31'b0, complete3}, 32'd0);
      check("rst_ovf", {31'b0, ovf3}, 32'd0);
      for (int e = 0; e < 9; e++) check("rst_c", c3[e*32 +: 32], 32'd0);

      // Identity times B
      load_identity3();
      rst3 = 1'b0;
      tick();
      check("id_busy", {31'b0, ready3}, 32'd0);
      repeat (35) tick();
      check("id_pre36", {31'b0, complete3}, 32'd0);
      tick();
      check("id_done37", {31'b0, complete3}, 32'd1);
      for (int e = 0; e < 9; e++) check("id_c", c3[e*32 +: 32], 32'h0001_0000 * (e + 1));
      check("id_ovf", {31'b0, ovf3}, 32'd0);

      // Scaled product
      rst3 = 1'b1;
      tick();
      for (int e = 0; e < 9; e++) begin
         a3[e*32 +: 32] = (e % 4 == 0) ? 32'h0002_0000 : 32'h0;
         b3[e*32 +: 32] = 32'h0001_8000;
      end
      rst3 = 1'b0;
      repeat (37) tick();
      check("sc_done", {31'b0, complete3}, 32'd1);
      for (int e = 0; e < 9; e++) check("sc_c", c3[e*32 +: 32], 32'h0003_0000);
      check("sc_ovf", {31'b0, ovf3}, 32'd0);

      // Transpose mode, 2x3x4
      check("tr_rst_ready", {31'b0, ready2}, 32'd1);
      for (int e = 0; e < 6; e++) a2[e*32 +: 32] = 32'h0001_0000 * (e + 1);
      for (int e = 0; e < 12; e++) begin
         b2[e*32 +: 32] = (e < 9 && (e % 4 == 0)) || e >= 9 ? 32'h0001_0000 : 32'h0;
      end
      tb2  = 1'b1;
      rst2 = 1'b0;
      repeat (32) tick();
      check("tr_pre32", {31'b0, complete2}, 32'd0);
      tick();
      check("tr_done33", {31'b0, complete2}, 32'd1);
      check("tr_c00", c2[0*32 +: 32], 32'h0001_0000);
      check("tr_c01", c2[1*32 +: 32], 32'h0002_0000);
      check("tr_c02", c2[2*32 +: 32], 32'h0003_0000);
      check("tr_c03", c2[3*32 +: 32], 32'h0006_0000);
      check("tr_c10", c2[4*32 +: 32], 32'h0004_0000);
      check("tr_c11", c2[5*32 +: 32], 32'h0005_0000);
      check("tr_c12", c2[6*32 +: 32], 32'h0006_0000);
      check("tr_c13", c2[7*32 +: 32], 32'h000F_0000);
      check("tr_ovf", {31'b0, ovf2}, 32'd0);

      // Saturation and rounding, 1x1x1
      run1(32'h7530_0000, 32'h7530_0000, 32'h7FFF_FFFF, 1'b1, "sat_pos");
      run1(32'h7530_0000, 32'h8AD0_0000, 32'h8000_0000, 1'b1, "sat_neg");
      run1(32'h0000_0001, 32'h0000_8000, 32'h0000_0001, 1'b0, "rnd_half");

      // Reset mid-run
      rst3 = 1'b1;
      tick();
      load_identity3();
      rst3 = 1'b0;
      repeat (9) tick();
      check("mid_partial_c0", c3[0*32 +: 32], 32'h0001_0000);
      rst3 = 1'b1;
      tick();
      check("mid_ready", {31'b0, ready3}, 32'd1);
      check("mid_complete", {31'b0, complete3}, 32'd0);
      check("mid_ovf", {31'b0, ovf3}, 32'd0);
      for (int e = 0; e < 9; e++) check("mid_c", c3[e*32 +: 32], 32'd0);
      rst3 = 1'b0;
      repeat (36) tick();
      check("mid_pre36", {31'b0, complete3}, 32'd0);
      tick();
      check("mid_done37", {31'b0, complete3}, 32'd1);
      for (int e = 0; e < 9; e++) check("mid_c_final", c3[e*32 +: 32], 32'h0001_0000 * (e + 1));

      // Hold in DONE while operands change
      for (int e = 0; e < 9; e++) snap[e] = 32'h0001_0000 * (e + 1);
      for (int n = 0; n < 20; n++) begin
         a3 = {9{$urandom()}};
         b3 = {9{$urandom()}};
         tb3 = n[0];
         tick();
      end
      check("hold_complete", {31'b0, complete3}, 32'd1);
      check("hold_ready", {31'b0, ready3}, 32'd0);
      for (int e = 0; e < 9; e++) check("hold_c", c3[e*32 +: 32], snap[e]);
      rst3 = 1'b1;
      tick();
      check("hold_rst_ready", {31'b0, ready3}, 32'd1);
      check("hold_rst_complete", {31'b0, complete3}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
